// File: rtl/fifo_umbral_pkg.sv
// rtl/fifo_umbral_pkg.sv - shared default sizes and width helper for fifo_umbral
package fifo_umbral_pkg;
  localparam int DEF_MEM_SIZE  = 8;
  localparam int DEF_WORD_SIZE = 12;
  localparam int DEF_PTR       = 3;

  // Occupancy must represent 0..MEM_SIZE inclusive, so one bit wider than a pointer.
  function automatic int cnt_width(input int ptr);
    return ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - register file with sync write port and registered, clearable read port
module fifo_mem
  import fifo_umbral_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_SIZE,
  parameter int WIDTH = DEF_WORD_SIZE,
  parameter int AW    = DEF_PTR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with programmable almost-full/empty thresholds and sticky error
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PTR       = DEF_PTR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic                 fifo_rd,
  input  logic [PTR-1:0]       full_threshold,
  input  logic [PTR-1:0]       empty_threshold,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);
  localparam int CNT_W = cnt_width(PTR);

  logic [PTR-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_ok, rd_ok;

  // A write into a full FIFO is still accepted when a read frees the slot this cycle.
  assign rd_ok = fifo_rd && (count != '0);
  assign wr_ok = fifo_wr && ((count < CNT_W'(MEM_SIZE)) || rd_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      error  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if ((fifo_wr && !wr_ok) || (fifo_rd && !rd_ok)) error <= 1'b1;
    end
  end

  fifo_mem #(
    .DEPTH (MEM_SIZE),
    .WIDTH (WORD_SIZE),
    .AW    (PTR)
  ) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (fifo_data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (fifo_data_out)
  );

  assign fifo_full    = (count == CNT_W'(MEM_SIZE));
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= {1'b0, full_threshold}) && !fifo_full;
  assign almost_empty = (count <= {1'b0, empty_threshold}) && !fifo_empty;
endmodule
